// File: rtl/eoc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// eoc_ctrl_pkg
// Shared constants for the end-of-computation control register block:
//   - register offsets (decoded from addr[4:3])
//   - FSM state encodings (RUN / EXITED / WDOG)
//   - the exit word forced on watchdog expiry
//   - byte_mask(): expands 8 byte enables into a 64-bit bit mask
// ---------------------------------------------------------------------------
package eoc_ctrl_pkg;

  // Register offsets as seen on addr[4:3]
  localparam logic [1:0] REG_EXIT          = 2'd0;
  localparam logic [1:0] REG_EVENT_TRIGGER = 2'd1;
  localparam logic [1:0] REG_CYCLE_COUNT   = 2'd2;
  localparam logic [1:0] REG_STATUS        = 2'd3;

  // FSM states; EXITED and WDOG are terminal until reset
  localparam logic [1:0] STATE_RUN    = 2'd0;
  localparam logic [1:0] STATE_EXITED = 2'd1;
  localparam logic [1:0] STATE_WDOG   = 2'd2;

  // Watchdog exit: code 0xFFFF in [63:1], done bit set -> 64'h1_FFFF
  localparam logic [15:0] WDOG_EXIT_CODE = 16'hFFFF;
  localparam logic [63:0] WDOG_EXIT_WORD = {47'd0, WDOG_EXIT_CODE, 1'b1};

  function automatic logic [63:0] byte_mask(input logic [7:0] be);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/eoc_ctrl_regs.sv
// ---------------------------------------------------------------------------
// eoc_ctrl_regs
// End-of-computation control registers. Software writes EXIT to stop the
// run (bit0 = done, [63:1] = exit code); an optional watchdog forces a
// failure exit after WatchdogCycles cycles in RUN.
//
// Optional feature macro: EOC_WATCHDOG_EN
//   defined   -> watchdog counter compiled in, FSM can enter WDOG
//   undefined -> no watchdog, STATUS bit1 always reads 0
//
// Register map (addr_i[4:3]):
//   0 EXIT (RW)  1 EVENT_TRIGGER (RW)  2 CYCLE_COUNT (RO)  3 STATUS (RO)
//
// Ports:
//   clk_i            clock, all state on rising edge
//   rst_ni           asynchronous active-low reset
//   req_i            access request (always granted in the same cycle)
//   we_i             1 = write, 0 = read
//   addr_i           byte address, only bits [4:3] decoded
//   wdata_i, be_i    write data and byte enables
//   gnt_o            grant, equal to req_i
//   rvalid_o         response valid one cycle after each request
//   rdata_o          read data (0 for writes)
//   err_o            response error, qualified by rvalid_o
//   exit_o           end-of-computation word
//   event_trigger_o  software event trigger value
// ---------------------------------------------------------------------------
import eoc_ctrl_pkg::*;

module eoc_ctrl_regs #(
  parameter int unsigned AddrWidth      = 64,
  parameter logic [63:0] WatchdogCycles = 64'd10_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [63:0]          exit_o,
  output logic [63:0]          event_trigger_o
);

  logic [1:0]  state_q;
  logic [63:0] exit_q;
  logic [63:0] event_q;
  logic [63:0] cycle_q;
  logic        rvalid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [1:0]  reg_sel;
  logic [63:0] wr_mask;
  logic [63:0] exit_merged;
  logic [63:0] event_merged;
  logic        in_run;
  logic        exit_wr_ok;
  logic        event_wr;
  logic        wdog_fire;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] status_word;

  // Only addr[4:3] selects a register; the rest is folded away here
  logic addr_unused;
  assign addr_unused = ^addr_i;

  assign reg_sel      = addr_i[4:3];
  assign wr_mask      = byte_mask(be_i);
  assign exit_merged  = (exit_q & ~wr_mask) | (wdata_i & wr_mask);
  assign event_merged = (event_q & ~wr_mask) | (wdata_i & wr_mask);
  assign in_run       = (state_q == STATE_RUN);
  assign exit_wr_ok   = req_i && we_i && (reg_sel == REG_EXIT) && in_run;
  assign event_wr     = req_i && we_i && (reg_sel == REG_EVENT_TRIGGER);

  // Bit0 reports any exit (software or watchdog), bit1 only the watchdog
  assign status_word = {62'd0, (state_q == STATE_WDOG), !in_run};

  assign gnt_o = req_i;

`ifdef EOC_WATCHDOG_EN
  logic [63:0] wdog_q;

  // Counts cycles spent in RUN; it stops once the FSM leaves RUN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if (in_run && (wdog_q != '1)) begin
      wdog_q <= wdog_q + 64'd1;
    end
  end

  // Fires on the edge where the counter reaches WatchdogCycles
  assign wdog_fire = in_run && ((wdog_q + 64'd1) >= WatchdogCycles);
`else
  logic [63:0] wdog_cycles_unused;
  assign wdog_cycles_unused = WatchdogCycles;
  assign wdog_fire          = 1'b0;
`endif

  // Response content for the request presented this cycle. Writes return
  // zero data; they error on read-only registers and on EXIT once the run
  // has ended. Reads never error.
  always_comb begin
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (req_i) begin
      if (we_i) begin
        unique case (reg_sel)
          REG_EXIT:          resp_err = !in_run;
          REG_EVENT_TRIGGER: resp_err = 1'b0;
          default:           resp_err = 1'b1;
        endcase
      end else begin
        unique case (reg_sel)
          REG_EXIT:          resp_rdata = exit_q;
          REG_EVENT_TRIGGER: resp_rdata = event_q;
          REG_CYCLE_COUNT:   resp_rdata = cycle_q;
          default:           resp_rdata = status_word;
        endcase
      end
    end
  end

  // One-cycle response pipeline; reset drops any response in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= resp_rdata;
      err_q    <= resp_err;
    end
  end

  // Exit FSM and EXIT register. A software exit in the same cycle as the
  // watchdog expiry wins; a non-exiting EXIT write in that cycle is
  // overridden by the watchdog word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STATE_RUN;
      exit_q  <= '0;
    end else if (exit_wr_ok && exit_merged[0]) begin
      state_q <= STATE_EXITED;
      exit_q  <= exit_merged;
    end else if (wdog_fire) begin
      state_q <= STATE_WDOG;
      exit_q  <= WDOG_EXIT_WORD;
    end else if (exit_wr_ok) begin
      exit_q  <= exit_merged;
    end
  end

  // Event trigger is writable regardless of FSM state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      event_q <= '0;
    end else if (event_wr) begin
      event_q <= event_merged;
    end
  end

  // Cycle counter runs only in RUN and saturates instead of wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q <= '0;
    end else if (in_run && (cycle_q != '1)) begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  assign rvalid_o        = rvalid_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;
  assign exit_o          = exit_q;
  assign event_trigger_o = event_q;

endmodule

// File: tb/tb_eoc_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_eoc_ctrl_regs
// Directed self-checking bench for eoc_ctrl_regs. Inputs change on the
// falling edge, outputs are sampled on the following falling edge.
// Watchdog scenarios compile only when EOC_WATCHDOG_EN is defined; the DUT
// is built with WatchdogCycles = 100.
// ---------------------------------------------------------------------------
module tb_eoc_ctrl_regs;

  localparam logic [1:0] SEL_EXIT   = 2'd0;
  localparam logic [1:0] SEL_EVENT  = 2'd1;
  localparam logic [1:0] SEL_CYCLE  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;
  logic [63:0] exit_word;
  logic [63:0] event_word;

  int n_checks = 0;
  int n_fails  = 0;

  // Results of the most recent transfer
  logic        r_gnt;
  logic        r_valid;
  logic [63:0] r_data;
  logic        r_err;

  eoc_ctrl_regs #(
    .AddrWidth      (64),
    .WatchdogCycles (64'd100)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .be_i            (be),
    .gnt_o           (gnt),
    .rvalid_o        (rvalid),
    .rdata_o         (rdata),
    .err_o           (err),
    .exit_o          (exit_word),
    .event_trigger_o (event_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two cycles and releases it on a falling edge
  task automatic do_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single request presented at the current falling edge; the response is
  // captured at the next falling edge. Upper/lower address bits carry junk.
  task automatic xfer(input logic w, input logic [1:0] sel,
                      input logic [63:0] d, input logic [7:0] b);
    req   = 1'b1;
    we    = w;
    addr  = {32'hDEAD_BEEF, 27'd0, sel, 3'b101};
    wdata = d;
    be    = b;
    #1 r_gnt = gnt;
    @(negedge clk);
    r_valid = rvalid;
    r_data  = rdata;
    r_err   = err;
    req     = 1'b0;
    we      = 1'b0;
    wdata   = '0;
    be      = '0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (exit_word !== 64'h0) begin n_fails++; $display("[TB] FAIL reset_exit: got %h expected %h", exit_word, 64'h0); end
    n_checks++; if (event_word !== 64'h0) begin n_fails++; $display("[TB] FAIL reset_event: got %h expected %h", event_word, 64'h0); end
    n_checks++; if (rvalid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h0) begin n_fails++; $display("[TB] FAIL reset_status: got %h expected %h", r_data, 64'h0); end
  endtask

  task automatic test_exit_write;
    do_reset;
    xfer(1'b1, SEL_EXIT, 64'h1, 8'hFF);
    n_checks++; if (r_gnt !== 1'b1) begin n_fails++; $display("[TB] FAIL exit_gnt: got %b expected 1", r_gnt); end
    n_checks++; if (r_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL exit_rvalid: got %b expected 1", r_valid); end
    n_checks++; if (r_err !== 1'b0) begin n_fails++; $display("[TB] FAIL exit_err: got %b expected 0", r_err); end
    n_checks++; if (exit_word !== 64'h1) begin n_fails++; $display("[TB] FAIL exit_word: got %h expected %h", exit_word, 64'h1); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h1) begin n_fails++; $display("[TB] FAIL exit_status: got %h expected %h", r_data, 64'h1); end
    // Exit took effect on the first edge after release, so the count froze at 1
    repeat (10) @(negedge clk);
    xfer(1'b0, SEL_CYCLE, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h1) begin n_fails++; $display("[TB] FAIL cycle_frozen: got %h expected %h", r_data, 64'h1); end
  endtask

  task automatic test_exit_locked;
    do_reset;
    xfer(1'b1, SEL_EXIT, 64'h7, 8'hFF);
    n_checks++; if (r_err !== 1'b0) begin n_fails++; $display("[TB] FAIL lock_first_err: got %b expected 0", r_err); end
    xfer(1'b1, SEL_EXIT, 64'h1, 8'hFF);
    n_checks++; if (r_err !== 1'b1) begin n_fails++; $display("[TB] FAIL lock_second_err: got %b expected 1", r_err); end
    n_checks++; if (exit_word !== 64'h7) begin n_fails++; $display("[TB] FAIL lock_exit_word: got %h expected %h", exit_word, 64'h7); end
  endtask

  task automatic test_exit_bytes;
    do_reset;
    xfer(1'b1, SEL_EXIT, 64'h6, 8'hFF);
    n_checks++; if (exit_word !== 64'h6) begin n_fails++; $display("[TB] FAIL exit_nodone_word: got %h expected %h", exit_word, 64'h6); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h0) begin n_fails++; $display("[TB] FAIL exit_nodone_status: got %h expected %h", r_data, 64'h0); end
    xfer(1'b1, SEL_EXIT, 64'h0000_0000_0000_FFFF, 8'h02);
    n_checks++; if (exit_word !== 64'hFF06) begin n_fails++; $display("[TB] FAIL exit_byte1: got %h expected %h", exit_word, 64'hFF06); end
    xfer(1'b1, SEL_EXIT, 64'hFFFF_FFFF_FFFF_FF01, 8'h01);
    n_checks++; if (exit_word !== 64'hFF01) begin n_fails++; $display("[TB] FAIL exit_byte0_done: got %h expected %h", exit_word, 64'hFF01); end
    xfer(1'b0, SEL_EXIT, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'hFF01) begin n_fails++; $display("[TB] FAIL exit_readback: got %h expected %h", r_data, 64'hFF01); end
  endtask

  task automatic test_event_bytes;
    do_reset;
    xfer(1'b1, SEL_EVENT, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    n_checks++; if (event_word !== 64'h0000_0000_FFFF_FFFF) begin n_fails++; $display("[TB] FAIL event_low: got %h expected %h", event_word, 64'h0000_0000_FFFF_FFFF); end
    n_checks++; if (r_err !== 1'b0) begin n_fails++; $display("[TB] FAIL event_err: got %b expected 0", r_err); end
    xfer(1'b1, SEL_EXIT, 64'h1, 8'hFF);
    xfer(1'b1, SEL_EVENT, 64'hAABB_CCDD_0000_0000, 8'hF0);
    n_checks++; if (event_word !== 64'hAABB_CCDD_FFFF_FFFF) begin n_fails++; $display("[TB] FAIL event_after_exit: got %h expected %h", event_word, 64'hAABB_CCDD_FFFF_FFFF); end
    xfer(1'b0, SEL_EVENT, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'hAABB_CCDD_FFFF_FFFF) begin n_fails++; $display("[TB] FAIL event_readback: got %h expected %h", r_data, 64'hAABB_CCDD_FFFF_FFFF); end
  endtask

  task automatic test_ro_writes;
    do_reset;
    xfer(1'b1, SEL_CYCLE, 64'h1234, 8'hFF);
    n_checks++; if (r_err !== 1'b1) begin n_fails++; $display("[TB] FAIL ro_cycle_err: got %b expected 1", r_err); end
    n_checks++; if (r_data !== 64'h0) begin n_fails++; $display("[TB] FAIL ro_cycle_rdata: got %h expected %h", r_data, 64'h0); end
    xfer(1'b1, SEL_STATUS, 64'h3, 8'hFF);
    n_checks++; if (r_err !== 1'b1) begin n_fails++; $display("[TB] FAIL ro_status_err: got %b expected 1", r_err); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h0) begin n_fails++; $display("[TB] FAIL ro_status_after: got %h expected %h", r_data, 64'h0); end
    n_checks++; if (r_err !== 1'b0) begin n_fails++; $display("[TB] FAIL ro_read_err: got %b expected 0", r_err); end
  endtask

  task automatic test_cycle_count;
    do_reset;
    repeat (5) @(posedge clk);
    @(negedge clk);
    xfer(1'b0, SEL_CYCLE, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'd5) begin n_fails++; $display("[TB] FAIL cycle_count: got %0d expected %0d", r_data, 5); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    req = 1'b1; we = 1'b1; addr = {59'd0, SEL_EVENT, 3'b000}; wdata = 64'h55; be = 8'hFF;
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_wr_rvalid: got %b expected 1", rvalid); end
    we = 1'b0; addr = {59'd0, SEL_EVENT, 3'b000}; wdata = '0; be = '0;
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_rd_rvalid: got %b expected 1", rvalid); end
    n_checks++; if (rdata !== 64'h55) begin n_fails++; $display("[TB] FAIL b2b_rd_data: got %h expected %h", rdata, 64'h55); end
    addr = {59'd0, SEL_STATUS, 3'b000};
    @(negedge clk);
    n_checks++; if (rdata !== 64'h0) begin n_fails++; $display("[TB] FAIL b2b_status: got %h expected %h", rdata, 64'h0); end
    req = 1'b0;
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_idle_rvalid: got %b expected 0", rvalid); end
  endtask

  task automatic test_reset_mid_read;
    do_reset;
    xfer(1'b1, SEL_EVENT, 64'h1234, 8'hFF);
    xfer(1'b1, SEL_EXIT, 64'h6, 8'hFF);
    req = 1'b1; we = 1'b0; addr = {59'd0, SEL_CYCLE, 3'b000};
    #2 rst_n = 1'b0;
    req = 1'b0;
    #1;
    n_checks++; if (exit_word !== 64'h0) begin n_fails++; $display("[TB] FAIL midrst_exit: got %h expected %h", exit_word, 64'h0); end
    n_checks++; if (event_word !== 64'h0) begin n_fails++; $display("[TB] FAIL midrst_event: got %h expected %h", event_word, 64'h0); end
    n_checks++; if ({rvalid, err, rdata} !== 66'h0) begin n_fails++; $display("[TB] FAIL midrst_resp: got %b/%b/%h expected 0/0/0", rvalid, err, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rvalid !== 1'b0) begin n_fails++; $display("[TB] FAIL midrst_no_rvalid: cycle %0d got %b expected 0", i, rvalid); end
    end
  endtask

`ifdef EOC_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset;
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_checks++; if (exit_word !== 64'h0) begin n_fails++; $display("[TB] FAIL wdog_early: got %h expected %h", exit_word, 64'h0); end
    @(negedge clk);
    n_checks++; if (exit_word !== 64'h1_FFFF) begin n_fails++; $display("[TB] FAIL wdog_exit: got %h expected %h", exit_word, 64'h1_FFFF); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h3) begin n_fails++; $display("[TB] FAIL wdog_status: got %h expected %h", r_data, 64'h3); end
    xfer(1'b0, SEL_CYCLE, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'd100) begin n_fails++; $display("[TB] FAIL wdog_cycle: got %0d expected %0d", r_data, 100); end
    xfer(1'b1, SEL_EXIT, 64'h1, 8'hFF);
    n_checks++; if (r_err !== 1'b1) begin n_fails++; $display("[TB] FAIL wdog_exit_err: got %b expected 1", r_err); end
    n_checks++; if (exit_word !== 64'h1_FFFF) begin n_fails++; $display("[TB] FAIL wdog_exit_kept: got %h expected %h", exit_word, 64'h1_FFFF); end
  endtask

  task automatic test_exit_vs_wdog;
    do_reset;
    repeat (99) @(posedge clk);
    @(negedge clk);
    xfer(1'b1, SEL_EXIT, 64'h1, 8'hFF);
    n_checks++; if (r_err !== 1'b0) begin n_fails++; $display("[TB] FAIL race_err: got %b expected 0", r_err); end
    n_checks++; if (exit_word !== 64'h1) begin n_fails++; $display("[TB] FAIL race_exit: got %h expected %h", exit_word, 64'h1); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h1) begin n_fails++; $display("[TB] FAIL race_status: got %h expected %h", r_data, 64'h1); end
  endtask
`else
  task automatic test_no_watchdog;
    do_reset;
    repeat (150) @(negedge clk);
    n_checks++; if (exit_word !== 64'h0) begin n_fails++; $display("[TB] FAIL nowdog_exit: got %h expected %h", exit_word, 64'h0); end
    xfer(1'b0, SEL_CYCLE, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'd150) begin n_fails++; $display("[TB] FAIL nowdog_cycle: got %0d expected %0d", r_data, 150); end
    xfer(1'b0, SEL_STATUS, 64'h0, 8'h00);
    n_checks++; if (r_data !== 64'h0) begin n_fails++; $display("[TB] FAIL nowdog_status: got %h expected %h", r_data, 64'h0); end
  endtask
`endif

  initial begin
    test_reset;
    test_exit_write;
    test_exit_locked;
    test_exit_bytes;
    test_event_bytes;
    test_ro_writes;
    test_cycle_count;
    test_back_to_back;
    test_reset_mid_read;
`ifdef EOC_WATCHDOG_EN
    test_watchdog;
    test_exit_vs_wdog;
`else
    test_no_watchdog;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
